// File: rtl/param_core_fsm.sv
// Multi-cycle FETCH/EXEC/MEM core: 8 GPRs, loadable instruction memory, load/store data memory.
// The program is written through prog_* while idle or halted; dbg_* reads the register file.
module param_core_fsm #(
    parameter int DATA_W  = 8,
    parameter int IMEM_AW = 3,
    parameter int DMEM_AW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               prog_we_i,
    input  logic [IMEM_AW-1:0] prog_addr_i,
    input  logic [15:0]        prog_data_i,
    input  logic [2:0]         dbg_sel_i,
    output logic [DATA_W-1:0]  dbg_data_o,
    output logic [IMEM_AW-1:0] pc_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic               carry_o,
    output logic               zero_o
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_e             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [15:0]        ir_q, ir_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               busy_q, halted_q;
    logic [DATA_W-1:0]  regs_q [8];

    logic [15:0]        imem [2**IMEM_AW];
    logic [DATA_W-1:0]  dmem [2**DMEM_AW];
    logic [DATA_W-1:0]  dmem_rdata_q;

    logic [3:0]         op;
    logic [2:0]         rd, rs1, rs2;
    logic [7:0]         imm;
    logic [IMEM_AW-1:0] jmp_tgt;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  src_a, src_b, imm_ext, alu_res, reg_wdata;
    logic [DATA_W:0]    sum, diff;
    logic               reg_we, dmem_we, prog_ok;

    assign op        = ir_q[15:12];
    assign rd        = ir_q[11:9];
    assign rs1       = ir_q[8:6];
    assign rs2       = ir_q[5:3];
    assign imm       = ir_q[7:0];
    assign jmp_tgt   = imm[IMEM_AW-1:0];
    assign dmem_addr = imm[DMEM_AW-1:0];
    assign imm_ext   = DATA_W'(imm);
    assign src_a     = regs_q[rs1];
    assign src_b     = regs_q[rs2];
    // Top bit of diff is the borrow, i.e. set exactly when rs1 < rs2.
    assign sum       = {1'b0, src_a} + {1'b0, src_b};
    assign diff      = {1'b0, src_a} - {1'b0, src_b};
    assign prog_ok   = prog_we_i && (state_q == S_IDLE || state_q == S_HALT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        reg_we    = 1'b0;
        reg_wdata = '0;
        dmem_we   = 1'b0;
        alu_res   = '0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = imem[pc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + IMEM_AW'(1);
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        carry_d = 1'b0;
                        case (op)
                            OP_ADD:  begin alu_res = sum[DATA_W-1:0];  carry_d = sum[DATA_W];  end
                            OP_SUB:  begin alu_res = diff[DATA_W-1:0]; carry_d = diff[DATA_W]; end
                            OP_AND:  alu_res = src_a & src_b;
                            OP_OR:   alu_res = src_a | src_b;
                            default: alu_res = src_a ^ src_b;
                        endcase
                        zero_d    = (alu_res == '0);
                        reg_we    = 1'b1;
                        reg_wdata = alu_res;
                    end
                    OP_LDI: begin
                        reg_we    = 1'b1;
                        reg_wdata = imm_ext;
                    end
                    OP_LD:   state_d = S_MEM;
                    OP_ST:   dmem_we = 1'b1;
                    OP_JMP:  pc_d = jmp_tgt;
                    OP_JZ:   if (zero_q)  pc_d = jmp_tgt;
                    OP_JC:   if (carry_q) pc_d = jmp_tgt;
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                reg_we    = 1'b1;
                reg_wdata = dmem_rdata_q;
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            busy_q   <= (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_MEM);
            halted_q <= (state_d == S_HALT);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[rd] <= reg_wdata;
        end
    end

    // Memories carry no reset; a store is gated by state, so reset abandons it.
    always_ff @(posedge clk_i) begin
        if (prog_ok) imem[prog_addr_i] <= prog_data_i;
        if (dmem_we) dmem[dmem_addr] <= regs_q[rd];
        dmem_rdata_q <= dmem[dmem_addr];
    end

    assign dbg_data_o = regs_q[dbg_sel_i];
    assign pc_o       = pc_q;
    assign busy_o     = busy_q;
    assign halted_o   = halted_q;
    assign carry_o    = carry_q;
    assign zero_o     = zero_q;
endmodule

// File: tb/tb_param_core_fsm.sv
// Bench for param_core_fsm: instruction-level reference model checked every cycle, directed
// programs with literal expectations, then randomized programs, starts, writes and resets.
module tb_param_core_fsm;
    localparam int MASK   = 255;
    localparam int IDEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, prog_we = 1'b0;
    logic [2:0]  prog_addr = '0, dbg_sel = '0;
    logic [15:0] prog_data = '0;
    logic [7:0]  dbg_data;
    logic [2:0]  pc;
    logic        busy, halted, carry, zero;

    logic        st16 = 1'b0, we16 = 1'b0;
    logic [2:0]  wa16 = '0, sel16 = '0, pc16;
    logic [15:0] wd16 = '0, dbg16;
    logic        busy16, halted16, carry16, zero16;

    param_core_fsm #(.DATA_W(8), .IMEM_AW(3), .DMEM_AW(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .prog_we_i(prog_we),
        .prog_addr_i(prog_addr), .prog_data_i(prog_data), .dbg_sel_i(dbg_sel),
        .dbg_data_o(dbg_data), .pc_o(pc), .busy_o(busy), .halted_o(halted),
        .carry_o(carry), .zero_o(zero));

    param_core_fsm #(.DATA_W(16), .IMEM_AW(3), .DMEM_AW(8)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st16), .prog_we_i(we16),
        .prog_addr_i(wa16), .prog_data_i(wd16), .dbg_sel_i(sel16),
        .dbg_data_o(dbg16), .pc_o(pc16), .busy_o(busy16), .halted_o(halted16),
        .carry_o(carry16), .zero_o(zero16));

    always #20 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Reference model: whole instructions retire at once after their cycle latency.
    int          m_regs [8];
    int          m_dmem [256];
    logic [15:0] m_imem [8];
    logic [15:0] m_ir;
    int          m_pc, m_cnt;
    bit          m_c, m_z, m_run, m_halt;

    logic [15:0] prog [8];
    bit          tr_b [64];
    bit          tr_z [64];
    bit          tr_c [64];

    function automatic logic [15:0] enc_r(logic [3:0] op, logic [2:0] rd, logic [2:0] a, logic [2:0] b);
        return {op, rd, a, b, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(logic [3:0] op, logic [2:0] rd, logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        int k;
        w = 16'($urandom);
        k = $urandom_range(0, 19);
        if (k < 5)        w[15:12] = 4'(k);
        else if (k < 7)   w[15:12] = 4'h8;
        else if (k == 7)  begin w[15:12] = 4'h9; w[7:0] = 8'($urandom_range(0, 6)); end
        else if (k == 8)  begin w[15:12] = 4'hA; w[7:0] = 8'($urandom_range(0, 6)); end
        else if (k == 9)  w[15:12] = 4'hC;
        else if (k < 12)  w[15:12] = 4'hD;
        else if (k < 14)  w[15:12] = 4'hE;
        else if (k == 14) w[15:12] = 4'hF;
        else if (k == 15) w[15:12] = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'hB;
        else              w[15:12] = 4'($urandom_range(0, 4));
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc = 0; m_cnt = 0; m_c = 0; m_z = 0; m_run = 0; m_halt = 0;
    endtask

    task automatic m_exec();
        int a, b, r;
        logic [3:0] op;
        logic [2:0] rd;
        logic [7:0] imm;
        op = m_ir[15:12]; rd = m_ir[11:9]; imm = m_ir[7:0];
        a = m_regs[m_ir[8:6]]; b = m_regs[m_ir[5:3]];
        r = 0;
        m_pc = (m_pc + 1) % IDEPTH;
        case (op)
            4'h0: begin r = a + b; m_c = (r > MASK); end
            4'h1: begin r = a - b; m_c = (a < b); end
            4'h2: begin r = a & b; m_c = 0; end
            4'h3: begin r = a | b; m_c = 0; end
            4'h4: begin r = a ^ b; m_c = 0; end
            4'h8: m_regs[rd] = int'(imm);
            4'h9: m_regs[rd] = m_dmem[imm];
            4'hA: m_dmem[imm] = m_regs[rd];
            4'hC: m_pc = int'(imm) % IDEPTH;
            4'hD: if (m_z) m_pc = int'(imm) % IDEPTH;
            4'hE: if (m_c) m_pc = int'(imm) % IDEPTH;
            4'hF: begin m_run = 0; m_halt = 1; end
            default: ;
        endcase
        if (op <= 4'h4) begin
            r = r & MASK;
            m_regs[rd] = r;
            m_z = (r == 0);
        end
    endtask

    task automatic m_edge(input bit st, input bit we, input logic [2:0] wa, input logic [15:0] wd);
        if (!m_run) begin
            if (we) m_imem[wa] = wd;
            if (st) begin m_run = 1; m_halt = 0; m_pc = 0; m_cnt = 0; end
        end else begin
            m_cnt++;
            if (m_cnt == 1) m_ir = m_imem[m_pc];
            else if (m_cnt == ((m_ir[15:12] == 4'h9) ? 3 : 2)) begin
                m_exec();
                m_cnt = 0;
            end
        end
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(m_run));
        chk("halted", 32'(halted), 32'(m_halt));
        if (!m_run || m_cnt == 0) begin
            chk("pc", 32'(pc), 32'(m_pc));
            chk("carry", 32'(carry), 32'(m_c));
            chk("zero", 32'(zero), 32'(m_z));
            for (int i = 0; i < 8; i++) begin
                dbg_sel = 3'(i);
                #1;
                chk($sformatf("r%0d", i), 32'(dbg_data), 32'(m_regs[i]));
            end
        end
    endtask

    task automatic cycle(input bit st, input bit we, input logic [2:0] wa, input logic [15:0] wd);
        start = st; prog_we = we; prog_addr = wa; prog_data = wd;
        @(posedge clk);
        m_edge(st, we, wa, wd);
        #1;
        compare();
        start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic mid_reset();
        #5;
        rst_n = 1'b0;
        #1;
        m_reset();
        compare();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic load_prog(input int n, input bit start_last);
        for (int i = 0; i < n; i++) cycle(start_last && (i == n - 1), 1'b1, 3'(i), prog[i]);
    endtask

    task automatic run_halt(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            cycle(1'b0, 1'b0, 3'd0, 16'd0);
            cyc++;
            tr_b[cyc] = busy; tr_z[cyc] = zero; tr_c[cyc] = carry;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic rd_reg(input int i, output logic [7:0] v);
        dbg_sel = 3'(i);
        #1;
        v = dbg_data;
    endtask

    initial begin
        int cyc;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) m_dmem[i] = 0;
        for (int i = 0; i < 8; i++) m_imem[i] = 16'h0;
        m_reset();
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_flags", {30'd0, carry, zero}, 32'd0);
        compare();
        #5 rst_n = 1'b1;

        // Clear the data words used by random loads, then halt at the last word.
        for (int i = 0; i < 7; i++) prog[i] = enc_i(4'hA, 3'd0, 8'(i));
        prog[7] = 16'hF000;
        load_prog(8, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 16'd0);
        run_halt(40, cyc);
        chk("init_cycles", 32'(cyc), 32'd16);

        // Test 1: start coincides with the final program write.
        mid_reset();
        prog[0] = enc_i(4'h8, 3'd0, 8'd7); prog[1] = enc_i(4'h8, 3'd1, 8'd2);
        prog[2] = enc_r(4'h0, 3'd7, 3'd0, 3'd1); prog[3] = 16'hF000;
        load_prog(4, 1'b1);
        run_halt(40, cyc);
        rd_reg(7, v);
        chk("t1_r7", 32'(v), 32'd9);
        chk("t1_cycles", 32'(cyc), 32'd8);
        chk("t1_busy7", 32'(tr_b[7]), 32'd1);
        chk("t1_flags", {30'd0, carry, zero}, 32'd0);
        $display("test 1 done at %0t", $time);

        // Test 2: ADD overflow to zero, then SUB borrow.
        mid_reset();
        prog[0] = enc_i(4'h8, 3'd0, 8'hFF); prog[1] = enc_i(4'h8, 3'd1, 8'h01);
        prog[2] = enc_r(4'h0, 3'd2, 3'd0, 3'd1); prog[3] = enc_r(4'h1, 3'd3, 3'd1, 3'd0);
        prog[4] = 16'hF000;
        load_prog(5, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 16'd0);
        run_halt(40, cyc);
        chk("t2_add_zero", 32'(tr_z[6]), 32'd1);
        chk("t2_add_carry", 32'(tr_c[6]), 32'd1);
        rd_reg(2, v); chk("t2_r2", 32'(v), 32'h00);
        rd_reg(3, v); chk("t2_r3", 32'(v), 32'h02);
        chk("t2_sub_carry", 32'(carry), 32'd1);
        chk("t2_sub_zero", 32'(zero), 32'd0);
        $display("test 2 done at %0t", $time);

        // Test 3: store then load back through the 3-cycle LD path.
        mid_reset();
        prog[0] = enc_i(4'h8, 3'd6, 8'h5A); prog[1] = enc_i(4'hA, 3'd6, 8'hFE);
        prog[2] = enc_i(4'h9, 3'd5, 8'hFE); prog[3] = 16'hF000;
        load_prog(4, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 16'd0);
        run_halt(40, cyc);
        rd_reg(5, v); chk("t3_r5", 32'(v), 32'h5A);
        chk("t3_cycles", 32'(cyc), 32'd9);
        chk("t3_busy8", 32'(tr_b[8]), 32'd1);
        chk("t3_flags", {30'd0, carry, zero}, 32'd0);
        $display("test 3 done at %0t", $time);

        // Test 4: JZ skips, execution runs off address 7 and wraps to 0.
        mid_reset();
        prog[0] = enc_i(4'hD, 3'd0, 8'd5); prog[1] = enc_r(4'h1, 3'd0, 3'd1, 3'd1);
        prog[2] = enc_i(4'hD, 3'd0, 8'd6); prog[3] = enc_i(4'h8, 3'd2, 8'd1);
        prog[4] = 16'hF000; prog[5] = 16'hF000;
        prog[6] = enc_i(4'h8, 3'd3, 8'd5); prog[7] = enc_i(4'h8, 3'd4, 8'd9);
        load_prog(8, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 16'd0);
        run_halt(40, cyc);
        rd_reg(2, v); chk("t4_r2", 32'(v), 32'd0);
        rd_reg(4, v); chk("t4_r4", 32'(v), 32'd9);
        chk("t4_cycles", 32'(cyc), 32'd14);
        chk("t4_pc", 32'(pc), 32'd6);
        $display("test 4 done at %0t", $time);

        // Test 5: writes while busy are dropped; reset during ADD's EXEC cycle.
        mid_reset();
        prog[0] = enc_i(4'h8, 3'd0, 8'd7); prog[1] = enc_i(4'h8, 3'd1, 8'd2);
        prog[2] = enc_r(4'h0, 3'd7, 3'd0, 3'd1); prog[3] = 16'hF000;
        load_prog(4, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 16'd0);
        for (int i = 1; i <= 5; i++) cycle(1'b0, (i <= 3), 3'd3, enc_i(4'h8, 3'd7, 8'h33));
        rd_reg(0, v); chk("t5_r0_before", 32'(v), 32'd7);
        mid_reset();
        rd_reg(0, v); chk("t5_r0_after", 32'(v), 32'd0);
        chk("t5_pc_after", 32'(pc), 32'd0);
        cycle(1'b1, 1'b0, 3'd0, 16'd0);
        run_halt(40, cyc);
        rd_reg(7, v); chk("t5_r7", 32'(v), 32'd9);
        chk("t5_cycles", 32'(cyc), 32'd8);
        $display("test 5 done at %0t", $time);

        // Test 6: 16-bit instance, immediate zero-extended with no truncation.
        wd16 = enc_i(4'h8, 3'd0, 8'hFF); wa16 = 3'd0; we16 = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 16'd0);
        wd16 = enc_r(4'h0, 3'd1, 3'd0, 3'd0); wa16 = 3'd1;
        cycle(1'b0, 1'b0, 3'd0, 16'd0);
        wd16 = 16'hF000; wa16 = 3'd2;
        cycle(1'b0, 1'b0, 3'd0, 16'd0);
        we16 = 1'b0; st16 = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 16'd0);
        st16 = 1'b0;
        for (int i = 0; i < 20 && !halted16; i++) cycle(1'b0, 1'b0, 3'd0, 16'd0);
        chk("t6_halted", 32'(halted16), 32'd1);
        sel16 = 3'd1; #1;
        chk("t6_r1", 32'(dbg16), 32'h01FE);
        chk("t6_carry", 32'(carry16), 32'd0);
        chk("t6_zero", 32'(zero16), 32'd0);
        chk("t6_pc", 32'(pc16), 32'd3);
        chk("t6_busy", 32'(busy16), 32'd0);
        $display("test 6 done at %0t", $time);

        // Randomized programs with stray starts, ignored writes and occasional resets.
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 3) == 0) mid_reset();
            for (int i = 0; i < 8; i++)
                cycle((i == 7) && ($urandom_range(0, 1) == 1), 1'b1, 3'(i), rand_instr());
            if (!m_run) cycle(1'b1, 1'b0, 3'd0, 16'd0);
            for (int c = 0; c < 60 && m_run; c++) begin
                cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 3'($urandom), rand_instr());
                if ($urandom_range(0, 99) == 0) mid_reset();
            end
            if (m_run) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
